// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: grid defaults,
// movement directions, cell coordinates and controller states.
package snake_pkg;

    localparam int DEFAULT_GRID_W    = 80;
    localparam int DEFAULT_GRID_H    = 60;
    localparam int DEFAULT_MAX_LEN   = 64;
    localparam int DEFAULT_START_LEN = 3;

    // The initial snake lies horizontally with its tail at (START_X, START_Y).
    localparam int START_X = 38;
    localparam int START_Y = 30;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
    } cell_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE_HEAD,
        ST_ERASE_TAIL,
        ST_DEAD
    } state_t;

    // Opposite directions differ only in the upper bit of the encoding.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic cell_t step_cell(input cell_t c, input dir_t d);
        cell_t n;
        n = c;
        case (d)
            DIR_RIGHT: n.x = c.x + 7'd1;
            DIR_DOWN:  n.y = c.y + 6'd1;
            DIR_LEFT:  n.x = c.x - 7'd1;
            DIR_UP:    n.y = c.y - 6'd1;
            default:   n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/snake_controller_body_fifo.sv
// Circular buffer of snake body cells: new heads are pushed, the tail is
// peeked and popped. Push and pop in the same cycle keep the count constant.
module body_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_LEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  cell_t                          push_cell,
    input  logic                           pop,
    output cell_t                          tail,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    cell_t          slots [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_cell;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign tail = slots[rd_ptr];

endmodule

// File: rtl/snake_controller.sv
// Snake game sequencer: clears and seeds the play-area RAM, then advances the
// snake on each tick while yielding the RAM port to the video scan.
module snake_controller
    import snake_pkg::*;
#(
    parameter int GRID_W    = DEFAULT_GRID_W,
    parameter int GRID_H    = DEFAULT_GRID_H,
    parameter int MAX_LEN   = DEFAULT_MAX_LEN,
    parameter int START_LEN = DEFAULT_START_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] dir,
    input  logic [6:0] food_x,
    input  logic [5:0] food_y,
    input  logic       scan_active,
    input  logic [6:0] scan_x,
    input  logic [5:0] scan_y,
    output logic [6:0] ram_x,
    output logic [5:0] ram_y,
    output logic       ram_we,
    output logic       ram_wdata,
    input  logic       ram_rdata,
    output logic       ate,
    output logic       game_over,
    output logic [6:0] length,
    output logic       busy
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [6:0]    LAST_X      = 7'(GRID_W - 1);
    localparam logic [5:0]    LAST_Y      = 6'(GRID_H - 1);
    localparam logic [6:0]    START_LEN_L = 7'(START_LEN);
    localparam logic [CW-1:0] MAX_COUNT   = CW'(MAX_LEN);

    state_t         state;
    cell_t          fsm_addr;
    logic           fsm_we;
    logic           fsm_wdata;
    dir_t           cur_dir;
    cell_t          head;
    cell_t          new_head;
    logic           grow;
    logic [6:0]     init_cnt;

    dir_t           req_dir;
    dir_t           move_dir;
    cell_t          step_head;
    cell_t          food;
    logic           wall_hit;

    logic           fifo_push;
    logic           fifo_pop;
    cell_t          push_cell;
    cell_t          fifo_tail;
    logic [CW-1:0]  fifo_count;

    assign req_dir   = dir_t'(dir);
    assign move_dir  = (req_dir == reverse_dir(cur_dir)) ? cur_dir : req_dir;
    assign step_head = step_cell(head, move_dir);
    assign food      = cell_t'({food_x, food_y});

    always_comb begin
        wall_hit = 1'b0;
        case (move_dir)
            DIR_RIGHT: wall_hit = (head.x == LAST_X);
            DIR_DOWN:  wall_hit = (head.y == LAST_Y);
            DIR_LEFT:  wall_hit = (head.x == 7'd0);
            DIR_UP:    wall_hit = (head.y == 6'd0);
            default:   wall_hit = 1'b0;
        endcase
    end

    // The scan wins the port outright; any game access simply waits a cycle.
    assign ram_x     = scan_active ? scan_x : fsm_addr.x;
    assign ram_y     = scan_active ? scan_y : fsm_addr.y;
    assign ram_we    = fsm_we && !scan_active;
    assign ram_wdata = fsm_wdata;

    // Body pushes happen in ERASE_TAIL together with any pop, so the buffer
    // never holds more than MAX_LEN cells even when the snake is full.
    assign fifo_push = ((state == ST_INIT) && !scan_active) ||
                       ((state == ST_ERASE_TAIL) && (!fsm_we || !scan_active));
    assign fifo_pop  = (state == ST_ERASE_TAIL) && fsm_we && !scan_active;
    assign push_cell = (state == ST_INIT) ? fsm_addr : new_head;

    body_fifo #(
        .DEPTH(MAX_LEN)
    ) u_body_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_cell (push_cell),
        .pop       (fifo_pop),
        .tail      (fifo_tail),
        .count     (fifo_count)
    );

    // fsm_addr/fsm_we/fsm_wdata describe the access presented in the current
    // state; a state advances only once that access got through to the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            fsm_addr  <= '0;
            fsm_we    <= 1'b0;
            fsm_wdata <= 1'b0;
            cur_dir   <= DIR_RIGHT;
            head      <= '0;
            new_head  <= '0;
            grow      <= 1'b0;
            init_cnt  <= '0;
            ate       <= 1'b0;
            game_over <= 1'b0;
            length    <= '0;
            busy      <= 1'b1;
        end else begin
            ate <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (!fsm_we) begin
                        fsm_we <= 1'b1;
                    end else if (!scan_active) begin
                        if (fsm_addr.x == LAST_X) begin
                            fsm_addr.x <= '0;
                            if (fsm_addr.y == LAST_Y) begin
                                state     <= ST_INIT;
                                fsm_addr  <= '{x: 7'(START_X), y: 6'(START_Y)};
                                fsm_wdata <= 1'b1;
                                init_cnt  <= '0;
                            end else begin
                                fsm_addr.y <= fsm_addr.y + 6'd1;
                            end
                        end else begin
                            fsm_addr.x <= fsm_addr.x + 7'd1;
                        end
                    end
                end

                ST_INIT: begin
                    if (!scan_active) begin
                        if (init_cnt == START_LEN_L - 7'd1) begin
                            state     <= ST_IDLE;
                            fsm_we    <= 1'b0;
                            fsm_wdata <= 1'b0;
                            head      <= fsm_addr;
                            cur_dir   <= DIR_RIGHT;
                            length    <= START_LEN_L;
                            busy      <= 1'b0;
                        end else begin
                            fsm_addr.x <= fsm_addr.x + 7'd1;
                            init_cnt   <= init_cnt + 7'd1;
                        end
                    end
                end

                ST_IDLE: begin
                    if (tick) begin
                        cur_dir <= move_dir;
                        busy    <= 1'b1;
                        if (wall_hit) begin
                            state     <= ST_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            state    <= ST_READ;
                            new_head <= step_head;
                            fsm_addr <= step_head;
                        end
                    end
                end

                ST_READ: begin
                    if (!scan_active) begin
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (ram_rdata) begin
                        state     <= ST_DEAD;
                        game_over <= 1'b1;
                    end else begin
                        state     <= ST_WRITE_HEAD;
                        grow      <= (new_head == food);
                        ate       <= (new_head == food);
                        fsm_we    <= 1'b1;
                        fsm_wdata <= 1'b1;
                    end
                end

                ST_WRITE_HEAD: begin
                    if (!scan_active) begin
                        state     <= ST_ERASE_TAIL;
                        head      <= new_head;
                        fsm_addr  <= fifo_tail;
                        fsm_wdata <= 1'b0;
                        fsm_we    <= !(grow && (fifo_count < MAX_COUNT));
                    end
                end

                ST_ERASE_TAIL: begin
                    if (!fsm_we || !scan_active) begin
                        if (!fsm_we) begin
                            length <= length + 7'd1;
                        end
                        state  <= ST_IDLE;
                        fsm_we <= 1'b0;
                        busy   <= 1'b0;
                    end
                end

                ST_DEAD: begin
                    fsm_we    <= 1'b0;
                    game_over <= 1'b1;
                end

                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_controller.sv
// Directed bench for snake_controller with a behavioural 80x60 cell RAM that
// logs every write the controller issues.
module tb_snake_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [6:0] food_x = 7'd0;
    logic [5:0] food_y = 6'd0;
    logic       scan_active = 1'b0;
    logic [6:0] scan_x = 7'd0;
    logic [5:0] scan_y = 6'd0;
    logic [6:0] ram_x;
    logic [5:0] ram_y;
    logic       ram_we;
    logic       ram_wdata;
    logic       ram_rdata = 1'b0;
    logic       ate;
    logic       game_over;
    logic [6:0] length;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    wr_t  wlog [$];
    int   ate_cycles = 0;
    bit   mem [0:4799] = '{default: 1'b1};
    logic poke_en = 1'b0;
    int   poke_idx = 0;

    snake_controller dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .dir         (dir),
        .food_x      (food_x),
        .food_y      (food_y),
        .scan_active (scan_active),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .ram_x       (ram_x),
        .ram_y       (ram_y),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ate         (ate),
        .game_over   (game_over),
        .length      (length),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model; starts all ones so a missed clear shows up.
    always @(posedge clk) begin
        int idx;
        idx = int'(ram_y) * 80 + int'(ram_x);
        if (ram_we === 1'b1) begin
            wlog.push_back('{int'(ram_x), int'(ram_y), int'(ram_wdata)});
            if (idx < 4800) mem[idx] <= ram_wdata;
        end
        if (poke_en) mem[poke_idx] <= 1'b1;
        ram_rdata <= (idx < 4800) ? mem[idx] : 1'b0;
        if (ate === 1'b1) ate_cycles++;
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Writes are encoded as x*1000 + y*10 + data, e.g. 41301 = (41,30) <- 1.
    task automatic check_write(input string tag, input int idx, input int x, input int y, input int d);
        int obs;
        obs = -1;
        if (idx >= 0 && idx < wlog.size()) obs = wlog[idx].x * 1000 + wlog[idx].y * 10 + wlog[idx].d;
        check_output(tag, obs, x * 1000 + y * 10 + d);
    endtask

    task automatic tick_step(input logic [1:0] d, output int cycles);
        @(negedge clk);
        dir = d;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cycles = 1;
        while (busy === 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (busy !== 1'b0 && cycles < 6000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int base;
        int bad;
        int a0;

        // Reset values
        repeat (2) @(negedge clk);
        check_output("rst_ram_we", int'(ram_we), 0);
        check_output("rst_ram_wdata", int'(ram_wdata), 0);
        check_output("rst_ate", int'(ate), 0);
        check_output("rst_game_over", int'(game_over), 0);
        check_output("rst_length", int'(length), 0);
        check_output("rst_busy", int'(busy), 1);

        // Clear sweep and initial snake
        base = wlog.size();
        reset = 1'b0;
        wait_init(cyc);
        check_output("init_done", int'(busy), 0);
        check_output("init_write_count", wlog.size() - base, 4803);
        bad = 0;
        for (int i = 0; i < 4800; i++) begin
            if (base + i >= wlog.size()) bad++;
            else if (wlog[base+i].x != i % 80 || wlog[base+i].y != i / 80 || wlog[base+i].d != 0) bad++;
        end
        check_output("clear_sweep", bad, 0);
        check_write("init_cell0", base + 4800, 38, 30, 1);
        check_write("init_cell1", base + 4801, 39, 30, 1);
        check_write("init_cell2", base + 4802, 40, 30, 1);
        check_output("init_length", int'(length), 3);

        // Plain step right, no food
        base = wlog.size();
        a0 = ate_cycles;
        tick_step(2'b00, cyc);
        check_output("step_cycles", cyc, 5);
        check_output("step_write_count", wlog.size() - base, 2);
        check_write("step_head", base, 41, 30, 1);
        check_write("step_tail", base + 1, 38, 30, 0);
        check_output("step_length", int'(length), 3);
        check_output("step_no_ate", ate_cycles - a0, 0);

        // Eat food at (42,30): no tail erase, length grows
        food_x = 7'd42;
        food_y = 6'd30;
        base = wlog.size();
        a0 = ate_cycles;
        tick_step(2'b00, cyc);
        check_output("grow_cycles", cyc, 5);
        check_output("grow_ate_pulse", ate_cycles - a0, 1);
        check_output("grow_write_count", wlog.size() - base, 1);
        check_write("grow_head", base, 42, 30, 1);
        check_output("grow_length", int'(length), 4);
        food_x = 7'd0;
        food_y = 6'd0;

        // Reverse request is ignored
        base = wlog.size();
        tick_step(2'b10, cyc);
        check_write("reverse_head", base, 43, 30, 1);
        check_write("reverse_tail", base + 1, 39, 30, 0);

        // Turn up
        base = wlog.size();
        tick_step(2'b11, cyc);
        check_write("up_head", base, 43, 29, 1);
        check_write("up_tail", base + 1, 40, 30, 0);
        check_output("up_length", int'(length), 4);

        // Scan owns the port for 10 cycles while the step sits in READ
        base = wlog.size();
        @(negedge clk);
        dir = 2'b00;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        scan_active = 1'b1;
        scan_x = 7'd5;
        scan_y = 6'd5;
        cyc = 1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            cyc++;
            if (ram_we !== 1'b0 || ram_x !== 7'd5 || ram_y !== 6'd5) bad++;
        end
        scan_active = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_output("scan_mux", bad, 0);
        check_output("scan_cycles", cyc, 15);
        check_write("scan_head", base, 44, 29, 1);
        check_write("scan_tail", base + 1, 41, 30, 0);

        // Run right until the head reaches x=79
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            tick_step(2'b00, cyc);
            if (cyc != 5 || game_over !== 1'b0) bad++;
        end
        check_output("run_steps", bad, 0);
        check_write("run_last_head", wlog.size() - 2, 79, 29, 1);
        check_write("run_last_tail", wlog.size() - 1, 75, 29, 0);

        // Wall hit: game_over the cycle after the tick, no RAM access
        base = wlog.size();
        @(negedge clk);
        dir = 2'b00;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_output("wall_game_over", int'(game_over), 1);
        check_output("wall_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        dir = 2'b01;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (8) @(negedge clk);
        check_output("dead_no_writes", wlog.size() - base, 0);
        check_output("dead_sticky", int'(game_over), 1);
        check_output("dead_length", int'(length), 4);

        // Reset out of DEAD, replay the clear, then collide via a set cell
        reset = 1'b1;
        @(negedge clk);
        check_output("rerst_game_over", int'(game_over), 0);
        check_output("rerst_length", int'(length), 0);
        check_output("rerst_busy", int'(busy), 1);
        reset = 1'b0;
        wait_init(cyc);
        check_output("reinit_done", int'(busy), 0);
        check_output("reinit_length", int'(length), 3);
        poke_idx = 30 * 80 + 41;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
        base = wlog.size();
        @(negedge clk);
        dir = 2'b00;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check_output("hit_not_yet", int'(game_over), 0);
        @(negedge clk);
        check_output("hit_game_over", int'(game_over), 1);
        repeat (4) @(negedge clk);
        check_output("hit_no_writes", wlog.size() - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
